// File: rtl/puntuacion_pkg.sv
// Shared constants for the score display: score width, seven-segment
// patterns (active-low, seg[0]=a .. seg[6]=g), the converter state encoding,
// and the two small helpers used by the converter and the digit decoder.
package puntuacion_pkg;

  localparam int SCORE_W = 14;
  localparam int BCD_W   = 16;

  // Active-low segment patterns for a common-anode display.
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // Converter state encoding, kept as plain constants so existing tooling
  // that decodes the state register keeps working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Number of double-dabble iterations: one per input bit.
  localparam logic [3:0] LAST_SHIFT = 4'(SCORE_W - 1);

  // Decimal nibble to segment pattern; anything above 9 is shown blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = BLANK;
    endcase
    return pat;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 so the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_puntuacion_if.sv
// Bundle of the score display's data signals: the score going in and the
// display/BCD/status coming out. The master side is whoever supplies the
// score (score controller or a testbench); the slave side is the display.
interface display_puntuacion_if;
  import puntuacion_pkg::*;

  logic [SCORE_W-1:0] puntuacion;
  logic [6:0]         seg;
  logic [3:0]         an;
  logic [BCD_W-1:0]   bcd;
  logic               busy;

  modport master (
    output puntuacion,
    input  seg,
    input  an,
    input  bcd,
    input  busy
  );

  modport slave (
    input  puntuacion,
    output seg,
    output an,
    output bcd,
    output busy
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Watches its input while idle and starts a conversion only when the value
// differs from the one it last converted. A full conversion is
// LOAD + 14 x SHIFT + DONE = 16 busy cycles; bcd changes only in DONE, so
// it never shows a partial result.
module bin2bcd_seq
  import puntuacion_pkg::*;
#(
  parameter int MAX_VAL = 9999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] bin,
  input  logic               start,
  output logic [BCD_W-1:0]   bcd,
  output logic               busy
);

  localparam logic [SCORE_W-1:0] CLAMP = SCORE_W'(MAX_VAL);

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [SCORE_W-1:0] shift_q;    // clamped value, consumed MSB first
  logic [SCORE_W-1:0] raw_q;      // unclamped input captured in LOAD
  logic [SCORE_W-1:0] last_q;     // raw input of the last finished conversion
  logic [BCD_W-1:0]   scratch_q;  // BCD being built
  logic [BCD_W-1:0]   bcd_q;
  logic [3:0]         bit_cnt_q;
  logic [BCD_W-1:0]   adjusted;

  assign adjusted = dd_adjust(scratch_q);

  // Next-state logic: single path IDLE -> LOAD -> SHIFT x14 -> DONE -> IDLE.
  always_comb begin
    // NOTE: state_d gets a default first so no path through the case can
    // leave it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && (bin != last_q)) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (bit_cnt_q == LAST_SHIFT) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any conversion in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: capture/clamp in LOAD, one double-dabble step per SHIFT,
  // publish the result and remember the raw input in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      raw_q     <= '0;
      last_q    <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          raw_q     <= bin;
          shift_q   <= (bin > CLAMP) ? CLAMP : bin;
          scratch_q <= '0;
          bit_cnt_q <= '0;
        end
        ST_SHIFT: begin
          scratch_q <= {adjusted[BCD_W-2:0], shift_q[SCORE_W-1]};
          shift_q   <= {shift_q[SCORE_W-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        ST_DONE: begin
          bcd_q  <= scratch_q;
          last_q <= raw_q;
        end
        default: ;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/display_puntuacion.sv
// Four-digit multiplexed score display. The binary score is converted to
// BCD by bin2bcd_seq; a refresh divider walks the digit index and the
// registered an/seg outputs light one digit at a time, blanking leading
// zeros. Multiplexing continues during a conversion using the previous bcd.
module display_puntuacion
  import puntuacion_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int MAX_SCORE   = 9999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] puntuacion,
  output logic [6:0]         seg,
  output logic [3:0]         an,
  output logic [BCD_W-1:0]   bcd,
  output logic               busy
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] refresh_q;
  logic [1:0]       digit_q;
  logic [3:0]       nonzero;
  logic [3:0]       shown;
  logic [3:0]       nib;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;

  // Change detection lives inside the converter so the value recorded as
  // "last converted" is exactly the one captured in LOAD; it is always enabled.
  bin2bcd_seq #(
    .MAX_VAL (MAX_SCORE)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (puntuacion),
    .start (1'b1),
    .bcd   (bcd),
    .busy  (busy)
  );

  // Leading-zero blanking: a digit is shown if it or any higher digit is
  // nonzero; the units digit is always shown.
  always_comb begin
    for (int k = 0; k < 4; k++) nonzero[k] = |bcd[4*k +: 4];
    shown[3] = nonzero[3];
    shown[2] = nonzero[3] | nonzero[2];
    shown[1] = nonzero[3] | nonzero[2] | nonzero[1];
    shown[0] = 1'b1;
  end

  assign nib = bcd[{digit_q, 2'b00} +: 4];

  // Refresh divider: each digit stays lit REFRESH_DIV cycles, then the
  // index advances 0->1->2->3->0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      digit_q   <= '0;
    end else if (refresh_q == CNT_LAST) begin
      refresh_q <= '0;
      digit_q   <= digit_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + CNT_W'(1);
    end
  end

  // Registered digit drive: anode and segments update together on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 4'b1110;
      seg_q <= SEG_0;
    end else begin
      an_q  <= ~(4'b0001 << digit_q);
      seg_q <= shown[digit_q] ? seg_decode(nib) : BLANK;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_display_puntuacion.sv
// Testbench for display_puntuacion with REFRESH_DIV=4. Stimulus pushes the
// expected BCD of each conversion into a queue; a monitor pops and compares
// whenever busy falls, and also checks busy length, bcd stability and the
// anode rotation order.
module tb_display_puntuacion;
  import puntuacion_pkg::*;

  localparam int DIV = 4;

  logic clk;
  logic rst_n;
  display_puntuacion_if dp ();

  int checks   = 0;
  int failures = 0;
  int conv_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_bcd;

  display_puntuacion #(
    .REFRESH_DIV (DIV),
    .MAX_SCORE   (9999)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .puntuacion (dp.puntuacion),
    .seg        (dp.seg),
    .an         (dp.an),
    .bcd        (dp.bcd),
    .busy       (dp.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  logic        prev_busy = 1'b0;
  logic [3:0]  prev_an   = 4'b1110;
  logic [15:0] prev_bcd  = 16'h0000;
  int          busy_len  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      prev_an   = dp.an;
      prev_bcd  = dp.bcd;
      busy_len  = 0;
    end else begin
      if (dp.busy) busy_len++;
      if (prev_busy && !dp.busy) begin
        conv_cnt++;
        check("busy_len", 32'(busy_len), 32'd16);
        if (exp_q.size() == 0) begin
          check("unexpected_conversion", 32'(dp.bcd), 32'(prev_bcd));
        end else begin
          check("bcd_scoreboard", 32'(dp.bcd), 32'(exp_q.pop_front()));
        end
        busy_len = 0;
      end else if (dp.bcd != prev_bcd) begin
        check("bcd_changed_outside_done", 32'(dp.bcd), 32'(prev_bcd));
      end
      if (dp.an != prev_an)
        check("an_rotation", 32'(dp.an), 32'({prev_an[2:0], prev_an[3]}));
      prev_busy = dp.busy;
      prev_an   = dp.an;
      prev_bcd  = dp.bcd;
    end
  end

  // Apply a value at a negedge and check busy/bcd timing edge by edge:
  // busy rises on the first edge, bcd changes on the 16th edge after that.
  task automatic convert(input logic [13:0] val, input logic [15:0] exp_bcd);
    @(negedge clk);
    dp.puntuacion = val;
    exp_q.push_back(exp_bcd);
    @(posedge clk); #1;
    check("busy_rise", 32'(dp.busy), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    check("bcd_held_edge15", 32'(dp.bcd), 32'(cur_bcd));
    @(posedge clk); #1;
    check("bcd_update_edge16", 32'(dp.bcd), 32'(exp_bcd));
    check("busy_fall", 32'(dp.busy), 32'd0);
    cur_bcd = exp_bcd;
  endtask

  // Wait for each anode pattern in turn and check the segments shown.
  task automatic expect_digits(input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0);
    logic [6:0] exp_seg [4];
    logic [3:0] pat;
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      pat = ~(4'b0001 << k);
      for (int i = 0; i < 5 * DIV && dp.an != pat; i++) @(negedge clk);
      check("an_reached", 32'(dp.an), 32'(pat));
      check("seg_digit", 32'(dp.seg), 32'(exp_seg[k]));
    end
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b1;
    dp.puntuacion = '0;
    cur_bcd = 16'h0000;
    #1 rst_n = 1'b0;
    #1;
    check("rst_bcd", 32'(dp.bcd), 32'h0000);
    check("rst_an", 32'(dp.an), 32'b1110);
    check("rst_seg", 32'(dp.seg), 32'h40);
    check("rst_busy", 32'(dp.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_conv_after_reset", 32'(conv_cnt), 32'd0);
    check("idle_busy", 32'(dp.busy), 32'd0);

    convert(14'd1234, 16'h1234);
    expect_digits(SEG_1, SEG_2, SEG_3, SEG_4);

    convert(14'd12000, 16'h9999);
    expect_digits(SEG_9, SEG_9, SEG_9, SEG_9);

    convert(14'd7, 16'h0007);
    expect_digits(BLANK, BLANK, BLANK, SEG_7);

    // 500, then 501 arrives on the 5th busy cycle: both convert, in order.
    base = conv_cnt;
    @(negedge clk);
    dp.puntuacion = 14'd500;
    exp_q.push_back(16'h0500);
    exp_q.push_back(16'h0501);
    n = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin
      @(negedge clk);
      if (dp.busy) n++;
    end
    check("busy_seen_5", 32'(n), 32'd5);
    dp.puntuacion = 14'd501;
    for (int i = 0; i < 100 && conv_cnt < base + 2; i++) @(negedge clk);
    check("two_conversions", 32'(conv_cnt - base), 32'd2);
    check("bcd_501", 32'(dp.bcd), 32'h0501);
    cur_bcd = 16'h0501;
    expect_digits(BLANK, SEG_5, SEG_0, SEG_1);

    // Reset in the middle of converting 4321.
    @(negedge clk);
    dp.puntuacion = 14'd4321;
    repeat (6) @(negedge clk);
    check("busy_mid_conv", 32'(dp.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bcd", 32'(dp.bcd), 32'h0000);
    check("async_rst_an", 32'(dp.an), 32'b1110);
    check("async_rst_seg", 32'(dp.seg), 32'h40);
    check("async_rst_busy", 32'(dp.busy), 32'd0);
    @(negedge clk);
    exp_q.push_back(16'h4321);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("busy_rise_after_rst", 32'(dp.busy), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    check("bcd_held_after_rst", 32'(dp.bcd), 32'h0000);
    @(posedge clk); #1;
    check("bcd_4321", 32'(dp.bcd), 32'h4321);
    expect_digits(SEG_4, SEG_3, SEG_2, SEG_1);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("conversion_count", 32'(conv_cnt), 32'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_puntuacion.md
DISPLAY_PUNTUACION -- requirements
Module: display_puntuacion

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clk cycles each digit stays lit (1 kHz per digit at 50 MHz).
REQ-002 SHALL have parameter MAX_SCORE, default 9999, the clamp ceiling for the displayed value.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port puntuacion  input  14  binary score from the score controller, treated as unsigned.
REQ-006 SHALL have port seg  output  7  segment drive, seg[0]=a .. seg[6]=g, active-low (common anode).
REQ-007 SHALL have port an  output  4  digit enables, one-hot active-low, an[0]=units .. an[3]=thousands.
REQ-008 SHALL have port bcd  output  16  registered packed BCD of the displayed value, bcd[3:0]=units.
REQ-009 SHALL have port busy  output  1  high while a conversion is in progress.

Function
REQ-010 SHALL run converter FSM states IDLE, LOAD, SHIFT, DONE; sole path IDLE->LOAD->SHIFT(x14)->DONE->IDLE.
REQ-011 SHALL leave IDLE for LOAD only when puntuacion differs from the last converted input value; otherwise stay in IDLE.
REQ-012 SHALL in LOAD capture min(puntuacion, MAX_SCORE), clear the 16-bit BCD scratch, and zero a 4-bit bit counter.
REQ-013 SHALL in each SHIFT cycle add 3 to every scratch nibble >=5, then shift the captured value MSB into the scratch (double-dabble), for exactly 14 cycles.
REQ-014 SHALL in DONE copy scratch to bcd and record the captured raw input as last converted value.
REQ-015 SHALL update bcd exactly 16 clk edges after the IDLE cycle that detected the change; bcd holds its old value until then, never shows partial results.
REQ-016 SHALL assert busy in LOAD, SHIFT and DONE, and deassert it in IDLE.
REQ-017 SHALL ignore input changes while busy; the FSM re-compares on the next IDLE, so the latest value always wins.
REQ-018 SHALL run a refresh counter 0..REFRESH_DIV-1 that wraps to 0 and, on wrap, advances a 2-bit digit index 0->1->2->3->0.
REQ-019 SHALL drive an and seg as registered outputs, both changing on the same edge, for the current digit index.
REQ-020 SHALL blank (seg=7'h7F) leading-zero digits above the most significant nonzero digit; digit 0 is never blanked.
REQ-021 SHALL decode nibbles 0-9 to standard active-low patterns (0=7'h40, 1=7'h79, 7=7'h78, 8=7'h00); nibbles >9 decode to blank.
REQ-022 SHALL keep multiplexing uninterrupted during conversion, using the old bcd.

Reset
REQ-023 SHALL on rst_n low, immediately and regardless of clk, set state=IDLE, bcd=16'h0000, last converted value=0, busy=0.
REQ-024 SHALL on rst_n low also set refresh counter=0, digit index=0, an=4'b1110, seg=7'h40.
REQ-025 SHALL abort a conversion in progress on reset, with no bcd update; after release, a nonzero input is reconverted from IDLE.

Structure
REQ-026 SHALL place the segment pattern constants, BLANK=7'h7F, SCORE_W=14 and the FSM state encoding in shared package puntuacion_pkg.
REQ-027 SHALL implement the IDLE/LOAD/SHIFT/DONE converter as sub-module bin2bcd_seq (ports clk, rst_n, bin, start, bcd, busy); the top instantiates it plus the mux/decoder.

Verification (REFRESH_DIV=4 in bench)
REQ-028 SHALL check reset with puntuacion=0 -> bcd=16'h0000, an=4'b1110, seg=7'h40, busy=0, and no conversion afterwards.
REQ-029 SHALL check puntuacion 0->1234 -> busy high for 16 cycles, bcd=16'h1234 on edge 16; an then cycles 1110/1101/1011/0111 showing 4,3,2,1.
REQ-030 SHALL check puntuacion=12000 -> bcd=16'h9999, all four digits show 9.
REQ-031 SHALL check puntuacion=7 -> bcd=16'h0007; digits 1-3 seg=7'h7F, digit 0 seg=7'h78.
REQ-032 SHALL check 500 applied, then 501 on the 5th busy cycle -> bcd=16'h0500 first, then busy re-asserts and bcd=16'h0501; no other values appear.
REQ-033 SHALL check rst_n pulsed low mid-conversion of 4321 -> outputs at reset values asynchronously; after release bcd=16'h4321 16 edges after the first IDLE cycle.
